accel_pass_sequencer: RTL
=========================

Name: accel_pass_sequencer

Overview:
Host-side controller that sequences the accelerator core through N back-to-back convolution passes, such as kernel groups of one layer. For each pass it soft-resets the core, asserts run, waits for both the engine-done and psum-done status flags, and then advances to the next pass. It sits between the register file and the core, drives the core's control word, and reports pass index, busy, done, error and cycle count back to the host.

Parameters:
REG_WIDTH, 32, width of control, status and counter registers
SRST_CYCLES, 4, cycles that soft reset (ctrl[1]) is held per pass; must be 1 or more
GAP_CYCLES, 2, idle cycles between deasserting run and the next soft reset; 0 is allowed

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
i_start  in  1  single-cycle pulse; starts a job; ignored unless IDLE or DONE or ERR
i_abort  in  1  level; forces the job to end in ERR
i_num_pass  in  REG_WIDTH  passes per job; sampled on accepted start; 0 means the job completes immediately
i_timeout  in  REG_WIDTH  maximum RUN cycles per pass; sampled on accepted start; 0 disables the timeout
i_core_status  in  REG_WIDTH  core status word; [1] = engine done, [0] = psum done; other bits ignored
o_conf_ctrl  out  REG_WIDTH  core control word; [0] = run, [1] = soft reset; other bits 0
o_pass_idx  out  REG_WIDTH  index of the current or last pass
o_busy  out  1  high in every state except IDLE, DONE and ERR
o_done  out  1  high in DONE
o_err  out  1  high in ERR
o_err_code  out  2  error cause: 1 = timeout, 2 = abort; 0 otherwise
o_cycle_cnt  out  REG_WIDTH  cycles spent in RUN during the current pass; saturates at all-ones

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs 0, all internal counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE, DONE, ERR: on i_start, latch i_num_pass and i_timeout, clear pass_idx, err_code and cycle_cnt.
    - If the latched count is 0, go to DONE.
    - Otherwise go to SRST.
  - SRST: o_conf_ctrl = 2'b10, held for exactly SRST_CYCLES cycles, then go to RUN.
  - RUN: o_conf_ctrl = 2'b01. Each cycle, cycle_cnt increments (saturating).
    - Exit when i_core_status[1] and i_core_status[0] have both been seen high. They need not be high in the same cycle; each flag is held in a sticky latch cleared on RUN entry.
    - Both-done is only evaluated from the 3rd RUN cycle onward. This masks stale status from the core's registered status path.
    - On exit go to GAP.
  - GAP: o_conf_ctrl = 0 for GAP_CYCLES cycles.
    - Then, if pass_idx + 1 == num_pass, go to DONE with pass_idx unchanged.
    - Otherwise increment pass_idx and go to SRST.
    - With GAP_CYCLES = 0, GAP lasts 1 cycle for the decision.
- Timeout: in RUN with timeout != 0 and cycle_cnt == timeout - 1 and both-done not yet seen, go to ERR with err_code = 1 and o_conf_ctrl = 0.
- Abort: i_abort high in any busy state goes to ERR on the next edge with err_code = 2 and o_conf_ctrl forced to 2'b10 for one cycle, then 0.
- Priority:
  - Abort beats timeout, and timeout beats both-done in the same cycle.
  - i_start in the same cycle as i_abort while IDLE/DONE/ERR: start wins; abort only applies in busy states.
- i_start while busy is ignored, and the latched num_pass and timeout are not modified.
- Start latency: o_conf_ctrl[1] rises 1 cycle after the i_start edge.
- o_pass_idx and o_cycle_cnt hold their values in DONE and ERR for host readback.
- Reset asserted mid-job returns to IDLE immediately and drives o_conf_ctrl = 0, so the core is stopped in the same instant.

Test Plan:
1. rst low, then high; pulse i_start with num_pass = 1, timeout = 0, SRST_CYCLES = 4, GAP_CYCLES = 2; raise status = 2'b11 at RUN cycle 5 -> ctrl 2'b10 for exactly 4 cycles, then 2'b01 for 5 cycles, then 0 for 2 cycles; then done = 1, pass_idx = 0, cycle_cnt = 5.
2. num_pass = 3; status[1] pulses at RUN cycle 3 and status[0] at cycle 7 in each pass -> 3 SRST/RUN/GAP sequences, each RUN 7 cycles long; done with pass_idx = 2.
3. status = 2'b11 held high from before start -> both-done masked for the first 2 RUN cycles; RUN exits only after the 3rd cycle; no pass is skipped.
4. timeout = 10 and status never set -> err = 1, err_code = 1 after exactly 10 RUN cycles; ctrl = 0; cycle_cnt = 9; busy = 0.
5. i_abort in pass 1 of 3 during RUN -> next cycle err_code = 2, ctrl = 2'b10 for one cycle then 0; pass_idx = 1; a later i_start restarts the job from pass 0.
6. num_pass = 0 -> done on the cycle after start and ctrl never leaves 0; then i_start pulsed while busy during a 2-pass job -> ignored, job finishes with pass_idx = 1.

Source files
------------

// File: rtl/accel_pass_sequencer_if.sv
// Host/core-facing bundle of the pass sequencer: job control, core status and
// control word, and the status readback registers.
interface accel_pass_sequencer_if #(
   parameter int unsigned REG_WIDTH = 32
);
   logic                 i_start;
   logic                 i_abort;
   logic [REG_WIDTH-1:0] i_num_pass;
   logic [REG_WIDTH-1:0] i_timeout;
   logic [REG_WIDTH-1:0] i_core_status;
   logic [REG_WIDTH-1:0] o_conf_ctrl;
   logic [REG_WIDTH-1:0] o_pass_idx;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;
   logic [1:0]           o_err_code;
   logic [REG_WIDTH-1:0] o_cycle_cnt;

   modport master (
      output i_start, i_abort, i_num_pass, i_timeout, i_core_status,
      input  o_conf_ctrl, o_pass_idx, o_busy, o_done, o_err, o_err_code, o_cycle_cnt
   );

   modport slave (
      input  i_start, i_abort, i_num_pass, i_timeout, i_core_status,
      output o_conf_ctrl, o_pass_idx, o_busy, o_done, o_err, o_err_code, o_cycle_cnt
   );
endinterface

// File: rtl/accel_pass_sequencer.sv
// Sequences the accelerator core through N soft-reset/run/gap passes per job,
// with timeout and abort handling; every output is a registered copy of next state.
module accel_pass_sequencer #(
   parameter int unsigned REG_WIDTH   = 32,
   parameter int unsigned SRST_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   accel_pass_sequencer_if.slave bus
);

   localparam int unsigned GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
   localparam int unsigned PH_MAX  = (SRST_CYCLES > GAP_LEN) ? SRST_CYCLES : GAP_LEN;
   localparam int unsigned PH_W    = $clog2(PH_MAX) + 1;

   localparam logic [1:0] CTRL_RUN  = 2'b01;
   localparam logic [1:0] CTRL_SRST = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'd1;
   localparam logic [1:0] ERR_ABORT = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_SRST, S_RUN, S_GAP, S_DONE, S_ERR} state_t;

   state_t               r_state, w_state_nxt;
   logic [1:0]           r_ctrl, w_ctrl_nxt;
   logic [REG_WIDTH-1:0] r_pass_idx, w_pass_nxt;
   logic [REG_WIDTH-1:0] r_cycle_cnt, w_cnt_nxt;
   logic [1:0]           r_err_code, w_code_nxt;
   logic [REG_WIDTH-1:0] r_num_pass, w_num_nxt;
   logic [REG_WIDTH-1:0] r_timeout, w_tmo_nxt;
   logic [PH_W-1:0]      r_ph_cnt, w_ph_nxt;
   logic                 r_seen_eng, w_seen_eng_nxt;
   logic                 r_seen_psum, w_seen_psum_nxt;
   logic                 r_busy, r_done, r_err;

   logic w_busy_now, w_both_done, w_eval_ok, w_timeout_hit, w_unused;

   assign w_busy_now  = (r_state == S_SRST) || (r_state == S_RUN) || (r_state == S_GAP);
   assign w_both_done = (r_seen_eng | bus.i_core_status[1]) & (r_seen_psum | bus.i_core_status[0]);
   // First two RUN cycles may still carry the previous pass's status
   assign w_eval_ok   = (r_cycle_cnt >= REG_WIDTH'(2));
   assign w_timeout_hit = (r_timeout != '0) && (r_cycle_cnt == r_timeout - REG_WIDTH'(1)) &&
                          !(r_seen_eng && r_seen_psum);
   assign w_unused = ^bus.i_core_status[REG_WIDTH-1:2];

   always_comb begin
      w_state_nxt     = r_state;
      w_ctrl_nxt      = 2'b00;
      w_pass_nxt      = r_pass_idx;
      w_cnt_nxt       = r_cycle_cnt;
      w_code_nxt      = r_err_code;
      w_num_nxt       = r_num_pass;
      w_tmo_nxt       = r_timeout;
      w_ph_nxt        = r_ph_cnt;
      w_seen_eng_nxt  = r_seen_eng;
      w_seen_psum_nxt = r_seen_psum;
      unique case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.i_start) begin
               w_num_nxt  = bus.i_num_pass;
               w_tmo_nxt  = bus.i_timeout;
               w_pass_nxt = '0;
               w_code_nxt = 2'd0;
               w_cnt_nxt  = '0;
               w_ph_nxt   = '0;
               if (bus.i_num_pass == '0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_SRST;
                  w_ctrl_nxt  = CTRL_SRST;
               end
            end
         end
         S_SRST: begin
            if (r_ph_cnt == PH_W'(SRST_CYCLES - 1)) begin
               w_state_nxt     = S_RUN;
               w_ctrl_nxt      = CTRL_RUN;
               w_ph_nxt        = '0;
               w_cnt_nxt       = '0;
               w_seen_eng_nxt  = 1'b0;
               w_seen_psum_nxt = 1'b0;
            end else begin
               w_ph_nxt   = r_ph_cnt + PH_W'(1);
               w_ctrl_nxt = CTRL_SRST;
            end
         end
         S_RUN: begin
            if (w_timeout_hit) begin
               w_state_nxt = S_ERR;
               w_code_nxt  = ERR_TMO;
            end else begin
               w_cnt_nxt       = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + REG_WIDTH'(1);
               w_seen_eng_nxt  = r_seen_eng | bus.i_core_status[1];
               w_seen_psum_nxt = r_seen_psum | bus.i_core_status[0];
               if (w_eval_ok && w_both_done) begin
                  w_state_nxt = S_GAP;
                  w_ph_nxt    = '0;
               end else begin
                  w_ctrl_nxt = CTRL_RUN;
               end
            end
         end
         S_GAP: begin
            if (r_ph_cnt == PH_W'(GAP_LEN - 1)) begin
               if (r_pass_idx + REG_WIDTH'(1) == r_num_pass) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_pass_nxt  = r_pass_idx + REG_WIDTH'(1);
                  w_state_nxt = S_SRST;
                  w_ctrl_nxt  = CTRL_SRST;
                  w_ph_nxt    = '0;
               end
            end else begin
               w_ph_nxt = r_ph_cnt + PH_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Abort overrides everything in a busy state; core gets one soft-reset cycle
      if (w_busy_now && bus.i_abort) begin
         w_state_nxt     = S_ERR;
         w_code_nxt      = ERR_ABORT;
         w_ctrl_nxt      = CTRL_SRST;
         w_pass_nxt      = r_pass_idx;
         w_cnt_nxt       = r_cycle_cnt;
         w_ph_nxt        = r_ph_cnt;
         w_seen_eng_nxt  = r_seen_eng;
         w_seen_psum_nxt = r_seen_psum;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_ctrl      <= 2'b00;
         r_pass_idx  <= '0;
         r_cycle_cnt <= '0;
         r_err_code  <= 2'd0;
         r_num_pass  <= '0;
         r_timeout   <= '0;
         r_ph_cnt    <= '0;
         r_seen_eng  <= 1'b0;
         r_seen_psum <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ctrl      <= w_ctrl_nxt;
         r_pass_idx  <= w_pass_nxt;
         r_cycle_cnt <= w_cnt_nxt;
         r_err_code  <= w_code_nxt;
         r_num_pass  <= w_num_nxt;
         r_timeout   <= w_tmo_nxt;
         r_ph_cnt    <= w_ph_nxt;
         r_seen_eng  <= w_seen_eng_nxt;
         r_seen_psum <= w_seen_psum_nxt;
         r_busy      <= (w_state_nxt == S_SRST) || (w_state_nxt == S_RUN) || (w_state_nxt == S_GAP);
         r_done      <= (w_state_nxt == S_DONE);
         r_err       <= (w_state_nxt == S_ERR);
      end
   end

   assign bus.o_conf_ctrl = REG_WIDTH'(r_ctrl);
   assign bus.o_pass_idx  = r_pass_idx;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_err       = r_err;
   assign bus.o_err_code  = r_err_code;
   assign bus.o_cycle_cnt = r_cycle_cnt;

endmodule
